// File: rtl/alu_seq_pkg.sv
// Shared widths, function codes and FSM state type for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned FUNC_W   = 3;
    localparam int unsigned NUM_REGS = 4;

    localparam logic [FUNC_W-1:0] F_AND  = 3'b000;
    localparam logic [FUNC_W-1:0] F_OR   = 3'b001;
    localparam logic [FUNC_W-1:0] F_ADD  = 3'b010;
    localparam logic [FUNC_W-1:0] F_LOAD = 3'b011;
    localparam logic [FUNC_W-1:0] F_ANDN = 3'b100;
    localparam logic [FUNC_W-1:0] F_ORN  = 3'b101;
    localparam logic [FUNC_W-1:0] F_SUB  = 3'b110;
    localparam logic [FUNC_W-1:0] F_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and result channels of the sequencer; slave = sequencer side.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [FUNC_W-1:0] cmd_f;
    logic [IDX_W-1:0]  cmd_rd;
    logic [IDX_W-1:0]  cmd_ra;
    logic [IDX_W-1:0]  cmd_rb;
    logic              cmd_imm_en;
    logic [DATA_W-1:0] cmd_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [FUNC_W-1:0] alu_f;
    logic [DATA_W-1:0] alu_y;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic [DATA_W-1:0] ops_done;

    modport slave (
        input  cmd_valid, cmd_f, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_f,
        input  alu_y,
        output res_valid, res_data, res_zero, ops_done,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_f, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_f,
        output alu_y,
        input  res_valid, res_data, res_zero, ops_done,
        output res_ready
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [IDX_W-1:0]  rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] rf [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    assign ra_data = rf[ra_addr];
    assign rb_data = rf[rb_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one ALU/LOAD command at a time, drives the external ALU from registers,
// writes the result back to the register file and returns it on the result channel.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    alu_op_sequencer_if.slave  bus
);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [FUNC_W-1:0] alu_f_q, alu_f_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [DATA_W-1:0] ops_q, ops_d;
    logic [IDX_W-1:0]  rd_q, rd_d;

    logic              accept;
    logic              rf_we;
    logic [IDX_W-1:0]  rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;

    alu_seq_regfile u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (bus.cmd_ra),
        .ra_data (ra_data),
        .rb_addr (bus.cmd_rb),
        .rb_data (rb_data),
        .we      (rf_we),
        .wa      (rf_wa),
        .wd      (rf_wd)
    );

    assign accept = bus.cmd_valid && cmd_ready_q;

    // Handshake flags are registered copies of the next state so both sit low in reset.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_f_d     = alu_f_q;
        res_data_d  = res_data_q;
        ops_d       = ops_q;
        rd_d        = rd_q;
        rf_we       = 1'b0;
        rf_wa       = rd_q;
        rf_wd       = bus.alu_y;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.cmd_f == F_LOAD) begin
                        rf_we      = 1'b1;
                        rf_wa      = bus.cmd_rd;
                        rf_wd      = bus.cmd_imm;
                        res_data_d = bus.cmd_imm;
                        state_d    = RESP;
                    end else begin
                        alu_a_d = ra_data;
                        alu_b_d = bus.cmd_imm_en ? bus.cmd_imm : rb_data;
                        alu_f_d = bus.cmd_f;
                        rd_d    = bus.cmd_rd;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                rf_we      = 1'b1;
                res_data_d = bus.alu_y;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    ops_d   = ops_q + DATA_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        res_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            res_data_q  <= '0;
            ops_q       <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f_q     <= alu_f_d;
            res_data_q  <= res_data_d;
            ops_q       <= ops_d;
            rd_q        <= rd_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_f     = alu_f_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = (res_data_q == '0);
    assign bus.ops_done  = ops_q;

endmodule
